// File: rtl/apb_reg_master_if.sv
// apb_reg_master_if
//   Bundles the command/response handshake and the APB bus of apb_reg_master.
//   Parameter ADDR_WIDTH: APB/command address width.
//   Modports:
//     master - the apb_reg_master side (drives cmd_ready, rsp_*, APB control/address/data)
//     slave  - the opposite side (command issuer plus APB completer)
//   Signals:
//     cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command request handshake
//     rsp_valid/rsp_rdata/rsp_err/rsp_timeout           one-cycle completion report
//     PSEL/PENABLE/PWRITE/PADDR/PWDATA                  APB request
//     PRDATA/PREADY/PSLVERR                             APB response
interface apb_reg_master_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_wdata;

    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_reg_master.sv
// apb_reg_master
//   Turns single register commands into APB transfers (IDLE -> SETUP -> ACCESS -> RESP)
//   and reports each completion with a one-cycle rsp_valid pulse.
//   Parameters:
//     ADDR_WIDTH     APB address width (default 8)
//     TIMEOUT_CYCLES maximum PREADY-low ACCESS cycles, 1..255 (default 16)
//   Ports:
//     RegClk    clock, rising edge
//     RegReset  asynchronous active-high reset
//     bus       apb_reg_master_if.master: command, response and APB signals
//   Build option:
//     APB_REG_MASTER_TIMEOUT_EN  when defined, an 8-bit wait counter aborts an ACCESS phase
//     that sees TIMEOUT_CYCLES PREADY-low cycles; otherwise ACCESS waits forever and
//     rsp_timeout is tied low.
module apb_reg_master #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic              RegClk,
    input logic              RegReset,
    apb_reg_master_if.master bus
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                r_state;
    state_e                w_state_next;

    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [31:0]           r_pwdata;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  w_cmd_ready;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("apb_reg_master: TIMEOUT_CYCLES must be in 1..255");
    end

    // Held low during reset even though the state register already reads IDLE.
    assign w_cmd_ready = (r_state == StIdle) && !RegReset;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.cmd_valid && w_cmd_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = StSetup;
                end
            end
            StSetup: begin
                w_state_next = StAccess;
            end
            StAccess: begin
                // PSLVERR is only looked at on the PREADY=1 cycle.
                if (bus.PREADY) begin
                    w_done       = 1'b1;
                    w_state_next = StResp;
                end else if (w_timeout) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // APB control and rsp_valid are decoded from the next state so that every output
    // comes straight from a flop and still lines up with the state it belongs to.
    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            r_state     <= StIdle;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_psel      <= (w_state_next == StSetup) || (w_state_next == StAccess);
            r_penable   <= (w_state_next == StAccess);
            r_rsp_valid <= (w_state_next == StResp);
            if (w_accept) begin
                r_pwrite <= bus.cmd_write;
                r_paddr  <= bus.cmd_addr;
                r_pwdata <= bus.cmd_wdata;
            end
            if (w_done) begin
                r_rsp_err   <= bus.PSLVERR;
                r_rsp_rdata <= r_pwrite ? 32'd0 : bus.PRDATA;
            end else if (w_timeout) begin
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= 32'd0;
            end
        end
    end

`ifdef APB_REG_MASTER_TIMEOUT_EN
    // Timeout fires on the PREADY-low ACCESS cycle that would bring the count to
    // TIMEOUT_CYCLES; PREADY=1 on that same cycle completes normally instead.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_cnt;
    logic       r_rsp_timeout;

    assign w_timeout = (r_state == StAccess) && !bus.PREADY && (r_wait_cnt == WaitLast);

    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == StSetup) begin
            r_wait_cnt <= 8'd0;
        end else if ((r_state == StAccess) && !bus.PREADY) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_done) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_timeout <= 1'b1;
        end
    end

    assign bus.rsp_timeout = r_rsp_timeout;
`else
    assign w_timeout       = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_reg_master.sv
// tb_apb_reg_master
//   Directed bench for apb_reg_master: reset values, write/read with zero wait states,
//   slave error, wait states, back-to-back command stream, timeout (or endless wait when
//   APB_REG_MASTER_TIMEOUT_EN is undefined), reset during ACCESS, and recovery.
module tb_apb_reg_master;

    localparam int unsigned AW = 8;

    logic RegClk;
    logic RegReset;

    int checks = 0;
    int errors = 0;

    apb_reg_master_if #(.ADDR_WIDTH(AW)) bus_if ();

    apb_reg_master #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .RegClk  (RegClk),
        .RegReset(RegReset),
        .bus     (bus_if)
    );

    initial RegClk = 1'b0;
    always #5 RegClk = ~RegClk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge RegClk);
        #1;
    endtask

    // Compares {PSEL, PENABLE, rsp_valid}.
    task automatic check_ctl(input string tag, input logic [2:0] exp);
        check(tag, {29'd0, bus_if.PSEL, bus_if.PENABLE, bus_if.rsp_valid}, {29'd0, exp});
    endtask

    // Presents one command in an IDLE cycle; returns just after the accepting edge (SETUP).
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = wr;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_wdata = wdata;
        check("issue_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
        step();
        bus_if.cmd_valid = 1'b0;
    endtask

    initial begin
        int accepts;
        int accept_mask;
        int rsps;
        int bad_accept;
        int hang_bad;

        RegReset         = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_wdata = 32'd0;
        bus_if.PRDATA    = 32'd0;
        bus_if.PREADY    = 1'b1;
        bus_if.PSLVERR   = 1'b0;
        #2 RegReset = 1'b1;
        step();
        step();

        // Reset values
        check_ctl("rst_ctl", 3'b000);
        check("rst_ready", {31'd0, bus_if.cmd_ready}, 32'd0);
        check("rst_pwrite", {31'd0, bus_if.PWRITE}, 32'd0);
        check("rst_paddr", {24'd0, bus_if.PADDR}, 32'd0);
        check("rst_pwdata", bus_if.PWDATA, 32'd0);
        check("rst_rdata", bus_if.rsp_rdata, 32'd0);
        check("rst_err", {31'd0, bus_if.rsp_err}, 32'd0);
        check("rst_timeout", {31'd0, bus_if.rsp_timeout}, 32'd0);
        RegReset = 1'b0;
        #1 check("rel_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
        step();

        // Write 0x1F to 0x00, zero wait states
        issue(1'b1, 8'h00, 32'h0000_001F);
        check_ctl("wr_setup", 3'b100);
        check("wr_ready_busy", {31'd0, bus_if.cmd_ready}, 32'd0);
        check("wr_pwrite", {31'd0, bus_if.PWRITE}, 32'd1);
        check("wr_paddr", {24'd0, bus_if.PADDR}, 32'h00);
        check("wr_pwdata", bus_if.PWDATA, 32'h0000_001F);
        step();
        check_ctl("wr_access", 3'b110);
        step();
        check_ctl("wr_resp", 3'b001);
        check("wr_rdata", bus_if.rsp_rdata, 32'd0);
        check("wr_err", {31'd0, bus_if.rsp_err}, 32'd0);
        step();
        check_ctl("wr_idle", 3'b000);
        check("wr_next_ready", {31'd0, bus_if.cmd_ready}, 32'd1);

        // Read 0x00 returning 0x1F
        bus_if.PRDATA = 32'h0000_001F;
        issue(1'b0, 8'h00, 32'hFFFF_FFFF);
        check_ctl("rd_setup", 3'b100);
        check("rd_pwrite", {31'd0, bus_if.PWRITE}, 32'd0);
        step();
        check_ctl("rd_access", 3'b110);
        step();
        check_ctl("rd_resp", 3'b001);
        check("rd_rdata", bus_if.rsp_rdata, 32'h0000_001F);
        check("rd_err", {31'd0, bus_if.rsp_err}, 32'd0);
        step();

        // Read 0x04 with slave error
        bus_if.PRDATA  = 32'hDEAD_BEEF;
        bus_if.PSLVERR = 1'b1;
        issue(1'b0, 8'h04, 32'd0);
        check("err_paddr", {24'd0, bus_if.PADDR}, 32'h04);
        step();
        step();
        check_ctl("err_resp", 3'b001);
        check("err_err", {31'd0, bus_if.rsp_err}, 32'd1);
        check("err_rdata", bus_if.rsp_rdata, 32'hDEAD_BEEF);
        bus_if.PSLVERR = 1'b0;
        bus_if.PRDATA  = 32'd0;
        step();
        check_ctl("err_idle", 3'b000);
        check("err_hold_err", {31'd0, bus_if.rsp_err}, 32'd1);
        check("err_hold_rdata", bus_if.rsp_rdata, 32'hDEAD_BEEF);

        // Read with PREADY low for 3 ACCESS cycles; PSLVERR during wait is ignored
        bus_if.PREADY  = 1'b0;
        bus_if.PSLVERR = 1'b1;
        bus_if.PRDATA  = 32'h0000_0BAD;
        issue(1'b0, 8'h5A, 32'd0);
        check_ctl("ws_setup", 3'b100);
        check("ws_paddr_setup", {24'd0, bus_if.PADDR}, 32'h5A);
        for (int k = 2; k <= 5; k++) begin
            step();
            check_ctl("ws_access", 3'b110);
            check("ws_paddr", {24'd0, bus_if.PADDR}, 32'h5A);
        end
        bus_if.PREADY  = 1'b1;
        bus_if.PSLVERR = 1'b0;
        bus_if.PRDATA  = 32'h1234_5678;
        step();
        check_ctl("ws_resp", 3'b001);
        check("ws_rdata", bus_if.rsp_rdata, 32'h1234_5678);
        check("ws_err", {31'd0, bus_if.rsp_err}, 32'd0);
        check("ws_timeout", {31'd0, bus_if.rsp_timeout}, 32'd0);
        step();

        // cmd_valid held high for 10 cycles
        accepts     = 0;
        accept_mask = 0;
        rsps        = 0;
        bad_accept  = 0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 10) bus_if.cmd_valid = 1'b0;
            if (bus_if.cmd_valid && bus_if.cmd_ready) begin
                accepts++;
                accept_mask |= (1 << i);
                if (bus_if.PSEL || bus_if.rsp_valid) bad_accept++;
            end
            if (bus_if.rsp_valid) rsps++;
            bus_if.cmd_addr  = AW'(i);
            bus_if.cmd_wdata = 32'(i);
            step();
        end
        check("b2b_accepts", 32'(accepts), 32'd3);
        check("b2b_accept_cycles", 32'(accept_mask), 32'h111);
        check("b2b_rsps", 32'(rsps), 32'd3);
        check("b2b_bad_accept", 32'(bad_accept), 32'd0);
        check_ctl("b2b_idle", 3'b000);

        // Slave never ready
        bus_if.PREADY = 1'b0;
        bus_if.PRDATA = 32'h0000_CAFE;
        issue(1'b0, 8'h33, 32'd0);
`ifdef APB_REG_MASTER_TIMEOUT_EN
        for (int k = 2; k <= 5; k++) begin
            step();
            check_ctl("to_wait", 3'b110);
        end
        step();
        check_ctl("to_resp", 3'b001);
        check("to_err", {31'd0, bus_if.rsp_err}, 32'd1);
        check("to_timeout", {31'd0, bus_if.rsp_timeout}, 32'd1);
        check("to_rdata", bus_if.rsp_rdata, 32'd0);
        step();
        check_ctl("to_idle", 3'b000);
        check("to_hold", {31'd0, bus_if.rsp_timeout}, 32'd1);
        issue(1'b0, 8'h44, 32'd0);
        step();
`else
        hang_bad = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (!(bus_if.PSEL && bus_if.PENABLE) || bus_if.rsp_valid) hang_bad++;
        end
        check("hang_bad", 32'(hang_bad), 32'd0);
        check("hang_timeout", {31'd0, bus_if.rsp_timeout}, 32'd0);
        check("hang_ready", {31'd0, bus_if.cmd_ready}, 32'd0);
`endif

        // Reset pulse during ACCESS
        check_ctl("pre_rst", 3'b110);
        #2 RegReset = 1'b1;
        #1;
        check_ctl("rst_async", 3'b000);
        check("rst_async_ready", {31'd0, bus_if.cmd_ready}, 32'd0);
        step();
        check_ctl("rst_hold", 3'b000);
        RegReset      = 1'b0;
        bus_if.PREADY = 1'b1;
        #1 check("rst_rel_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
        rsps = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus_if.rsp_valid) rsps++;
        end
        check("rst_no_rsp", 32'(rsps), 32'd0);

        // Recovery write
        issue(1'b1, 8'hA5, 32'h5555_AAAA);
        check("rec_pwdata", bus_if.PWDATA, 32'h5555_AAAA);
        step();
        step();
        check_ctl("rec_resp", 3'b001);
        check("rec_rdata", bus_if.rsp_rdata, 32'd0);
        check("rec_timeout", {31'd0, bus_if.rsp_timeout}, 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
